// File: rtl/i2s_serializer_pkg.sv
// sftb_audio_pkg: shared audio framing constants and sample type for the I2S serializer
package sftb_audio_pkg;
  localparam int SAMPLE_W = 32;
  localparam int CHAN_W = 16;
  localparam int SLOTS_PER_FRAME = 32;
  localparam int BCLK_DIV_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int SLOT_W = $clog2(SLOTS_PER_FRAME);
  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/i2s_serializer_if.sv
// i2s_serializer_if: sample handshake into the serializer and the I2S lines out of it
interface i2s_serializer_if;
  import sftb_audio_pkg::*;
  sample_t x;
  logic x_valid;
  logic x_ready;
  logic bclk;
  logic lrclk;
  logic sdata;
  logic underrun;
  modport master(output x, x_valid, input x_ready, bclk, lrclk, sdata, underrun);
  modport slave(input x, x_valid, output x_ready, bclk, lrclk, sdata, underrun);
endinterface

// File: rtl/i2s_serializer_sample_fifo.sv
// sample_fifo: single-clock sample FIFO; caller guarantees no push when full and no pop when empty
module sample_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign dout_o = mem_q[rd_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  // storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  // pointers wrap naturally at the power-of-two depth; occupancy tracks push minus pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
endmodule

// File: rtl/i2s_serializer.sv
// i2s_serializer: buffers stereo samples and shifts them out as I2S with one-bit delay
module i2s_serializer import sftb_audio_pkg::*; #(
  parameter int BCLK_DIV = BCLK_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic c,
  input logic r,
  i2s_serializer_if.slave bus
);
  logic [7:0] div_q;
  logic bclk_q, lrclk_q, sdata_q, underrun_q, dly_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  sample_t sh_q, head;
  logic wrap, slot_ev, frame_ev, push, pop, full, empty;
  logic [$clog2(FIFO_DEPTH):0] count_unused;
  assign wrap = div_q == 8'(BCLK_DIV - 1);
  assign slot_ev = wrap && bclk_q;
  assign slot_d = slot_q + 1'b1;
  assign frame_ev = slot_ev && slot_q == '1;
  assign push = bus.x_valid && bus.x_ready;
  assign pop = frame_ev && !empty;
  assign bus.x_ready = !full;
  assign bus.bclk = bclk_q;
  assign bus.lrclk = lrclk_q;
  assign bus.sdata = sdata_q;
  assign bus.underrun = underrun_q;
  sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(c),
    .rst(r),
    .push_i(push),
    .pop_i(pop),
    .din_i(bus.x),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count_unused)
  );
  // bit clock divider, slot sequencing, and the shift path; everything moves on the bclk falling edge
  always_ff @(posedge c or posedge r)
    if (r) begin
      div_q <= '0;
      bclk_q <= 1'b0;
      slot_q <= '1;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      underrun_q <= 1'b0;
      sh_q <= '0;
      dly_q <= 1'b0;
    end else begin
      div_q <= wrap ? '0 : div_q + 8'd1;
      if (wrap) bclk_q <= !bclk_q;
      underrun_q <= frame_ev && empty;
      if (slot_ev) begin
        slot_q <= slot_d;
        lrclk_q <= slot_d[SLOT_W-1];
        sdata_q <= frame_ev ? dly_q : sh_q[SAMPLE_W-1];
        sh_q <= frame_ev ? (empty ? '0 : head) : {sh_q[SAMPLE_W-2:0], 1'b0};
        if (slot_q == SLOT_W'(SLOTS_PER_FRAME - 2)) dly_q <= sh_q[SAMPLE_W-2];
      end
    end
endmodule
